// File: rtl/vector_operand_sequencer_if.sv
// Handshake bundle between the ID-stage decoder, the vector operand sequencer and EX.
// master is the sequencer side; slave is the decoder/EX/register-file side.
interface vector_operand_sequencer_if #(
    parameter int LANES = 8,
    parameter int REG_W = 4,
    parameter int VL_W  = 7,
    parameter int GRP_W = 3
);
    logic             issue_valid;
    logic             issue_ready;
    logic [VL_W-1:0]  issue_vl;
    logic [REG_W-1:0] issue_vsrc;
    logic [REG_W-1:0] issue_vdst;
    logic             issue_scalar;
    logic [REG_W-1:0] rf_rd_addr;
    logic [GRP_W-1:0] rf_rd_group;
    logic             mux_ctrl;
    logic [LANES-1:0] lane_mask;
    logic [REG_W-1:0] wb_addr;
    logic             ex_valid;
    logic             ex_ready;
    logic             ex_last;
    logic             busy;
    logic             done;

    modport master (
        input  issue_valid, issue_vl, issue_vsrc, issue_vdst, issue_scalar, ex_ready,
        output issue_ready, rf_rd_addr, rf_rd_group, mux_ctrl, lane_mask, wb_addr,
               ex_valid, ex_last, busy, done
    );

    modport slave (
        output issue_valid, issue_vl, issue_vsrc, issue_vdst, issue_scalar, ex_ready,
        input  issue_ready, rf_rd_addr, rf_rd_group, mux_ctrl, lane_mask, wb_addr,
               ex_valid, ex_last, busy, done
    );
endinterface

// File: rtl/vector_operand_sequencer.sv
// Splits one vector instruction into LANES-wide groups and hands them to EX one per beat.
// Every output is decoded from registered state, so ex_ready/issue_valid never reach an output combinationally.
module vector_operand_sequencer #(
    parameter int LANES     = 8,
    parameter int MAX_ELEMS = 64,
    parameter int REG_W     = 4,
    parameter int VL_W      = 7,
    parameter int GRP_W     = 3
) (
    input logic clk,
    input logic rst,
    vector_operand_sequencer_if.master bus
);
    localparam int LG_W = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_r, state_nxt;
    logic [REG_W-1:0] vsrc_r, vdst_r;
    logic             scalar_r;
    logic [GRP_W-1:0] group_r, last_grp_r;
    logic [LG_W-1:0]  rem_r;
    logic [VL_W-1:0]  vl_eff;
    logic             accept, beat, is_last;

    function automatic logic [VL_W-1:0] sat_vl(input logic [VL_W-1:0] vl);
        if (vl > VL_W'(MAX_ELEMS)) begin
            return VL_W'(MAX_ELEMS);
        end
        return vl;
    endfunction

    // A zero remainder means the last group is completely full.
    function automatic logic [LANES-1:0] tail_mask(input logic [LG_W-1:0] rem);
        logic [LANES-1:0] m;
        for (int i = 0; i < LANES; i++) begin
            m[i] = (rem == '0) || (i < int'(rem));
        end
        return m;
    endfunction

    assign vl_eff  = sat_vl(bus.issue_vl);
    assign accept  = (state_r == IDLE) && bus.issue_valid;
    assign beat    = (state_r == RUN) && bus.ex_ready;
    assign is_last = (group_r == last_grp_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        unique case (state_r)
            IDLE: if (bus.issue_valid) state_nxt = (vl_eff == '0) ? DONE : RUN;
            RUN:  if (bus.ex_ready && is_last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Group counter stops at last_grp_r because the final beat leaves RUN instead of incrementing.
    always_ff @(posedge clk) begin
        if (rst) begin
            group_r <= '0;
        end else if (accept) begin
            group_r <= '0;
        end else if (beat && !is_last) begin
            group_r <= group_r + GRP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            vsrc_r     <= bus.issue_vsrc;
            vdst_r     <= bus.issue_vdst;
            scalar_r   <= bus.issue_scalar;
            last_grp_r <= GRP_W'((vl_eff - VL_W'(1)) >> LG_W);
            rem_r      <= vl_eff[LG_W-1:0];
        end
    end

    always_comb begin
        bus.issue_ready = (state_r == IDLE);
        bus.busy        = (state_r != IDLE);
        bus.done        = (state_r == DONE);
        bus.ex_valid    = 1'b0;
        bus.ex_last     = 1'b0;
        bus.rf_rd_addr  = '0;
        bus.rf_rd_group = '0;
        bus.wb_addr     = '0;
        bus.mux_ctrl    = 1'b0;
        bus.lane_mask   = '0;
        if (state_r == RUN) begin
            bus.ex_valid    = 1'b1;
            bus.ex_last     = is_last;
            bus.rf_rd_addr  = vsrc_r;
            bus.rf_rd_group = group_r;
            bus.wb_addr     = vdst_r;
            bus.mux_ctrl    = scalar_r;
            bus.lane_mask   = is_last ? tail_mask(rem_r) : '1;
        end
    end
endmodule

// File: tb/tb_vector_operand_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed beats and done markers, a negedge monitor pops and compares.
module tb_vector_operand_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    vector_operand_sequencer_if #(.LANES(8), .REG_W(4), .VL_W(7), .GRP_W(3)) bus ();

    vector_operand_sequencer #(
        .LANES(8), .MAX_ELEMS(64), .REG_W(4), .VL_W(7), .GRP_W(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit         is_done;
        logic [2:0] grp;
        logic [7:0] mask;
        logic       last;
        logic [3:0] addr;
        logic [3:0] wb;
        logic       mux;
    } exp_t;

    exp_t sbq[$];

    task automatic push_beat(input int g, input logic [7:0] m, input bit l,
                             input int a, input int w, input bit x);
        exp_t e;
        e.is_done = 1'b0;
        e.grp = 3'(g); e.mask = m; e.last = l; e.addr = 4'(a); e.wb = 4'(w); e.mux = x;
        sbq.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.grp = '0; e.mask = '0; e.last = 1'b0; e.addr = '0; e.wb = '0; e.mux = 1'b0;
        sbq.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every accepted beat and every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.ex_valid && bus.ex_ready) begin
            n_tests++;
            if (sbq.size() == 0 || sbq[0].is_done) begin
                n_fail++;
                $display("FAIL beat_unexpected: got grp=%0d mask=%h last=%0d, expected no beat",
                         bus.rf_rd_group, bus.lane_mask, bus.ex_last);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (bus.rf_rd_group !== e.grp || bus.lane_mask !== e.mask || bus.ex_last !== e.last ||
                    bus.rf_rd_addr !== e.addr || bus.wb_addr !== e.wb || bus.mux_ctrl !== e.mux) begin
                    n_fail++;
                    $display("FAIL beat: got grp=%0d mask=%h last=%0d addr=%0d wb=%0d mux=%0d, expected grp=%0d mask=%h last=%0d addr=%0d wb=%0d mux=%0d",
                             bus.rf_rd_group, bus.lane_mask, bus.ex_last, bus.rf_rd_addr, bus.wb_addr, bus.mux_ctrl,
                             e.grp, e.mask, e.last, e.addr, e.wb, e.mux);
                end
            end
        end
        if (bus.done) begin
            n_tests++;
            if (sbq.size() == 0 || !sbq[0].is_done) begin
                n_fail++;
                $display("FAIL done_unexpected: got done=1 with %0d pending entries, expected a done marker at head",
                         sbq.size());
            end else begin
                void'(sbq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_issue(input int vl, input int vsrc, input int vdst, input bit scalar);
        int t = 0;
        while (!bus.issue_ready && t < 50) begin
            tick();
            t++;
        end
        if (!bus.issue_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: got issue_ready=0, expected 1 within 50 cycles");
        end
        bus.issue_valid  = 1'b1;
        bus.issue_vl     = 7'(vl);
        bus.issue_vsrc   = 4'(vsrc);
        bus.issue_vdst   = 4'(vdst);
        bus.issue_scalar = scalar;
        tick();
        bus.issue_valid  = 1'b0;
        bus.issue_vl     = '0;
        bus.issue_vsrc   = '0;
        bus.issue_vdst   = '0;
        bus.issue_scalar = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((!bus.issue_ready || bus.busy) && t < 100) begin
            tick();
            t++;
        end
        check("idle_reached", 32'(bus.issue_ready), 32'd1);
    endtask

    initial begin
        bus.issue_valid  = 1'b0;
        bus.issue_vl     = '0;
        bus.issue_vsrc   = '0;
        bus.issue_vdst   = '0;
        bus.issue_scalar = 1'b0;
        bus.ex_ready     = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
        check("rst_ex_valid",    32'(bus.ex_valid),    32'd0);
        check("rst_busy",        32'(bus.busy),        32'd0);
        check("rst_done",        32'(bus.done),        32'd0);
        check("rst_outputs",
              {12'd0, bus.rf_rd_addr, bus.rf_rd_group, bus.mux_ctrl, bus.lane_mask, bus.wb_addr, bus.ex_last},
              32'd0);
        tick();
        rst = 1'b0;

        // vl=16: two full groups
        push_beat(0, 8'hFF, 0, 3, 5, 0);
        push_beat(1, 8'hFF, 1, 3, 5, 0);
        push_done();
        do_issue(16, 3, 5, 0);
        @(negedge clk);
        check("first_beat_latency", 32'(bus.ex_valid), 32'd1);
        wait_idle();

        // vl=13 scalar: partial tail mask, mux back to 0 in IDLE
        push_beat(0, 8'hFF, 0, 7, 2, 1);
        push_beat(1, 8'h1F, 1, 7, 2, 1);
        push_done();
        do_issue(13, 7, 2, 1);
        wait_idle();
        @(negedge clk);
        check("idle_mux_ctrl",  32'(bus.mux_ctrl),  32'd0);
        check("idle_lane_mask", 32'(bus.lane_mask), 32'd0);

        // vl=5: single partial group, also the last
        push_beat(0, 8'h1F, 1, 2, 4, 0);
        push_done();
        do_issue(5, 2, 4, 0);
        wait_idle();

        // vl=0: straight to DONE, no beat
        push_done();
        do_issue(0, 1, 1, 0);
        @(negedge clk);
        check("vl0_done",        32'(bus.done),        32'd1);
        check("vl0_ex_valid",    32'(bus.ex_valid),    32'd0);
        check("vl0_issue_ready", 32'(bus.issue_ready), 32'd0);
        tick();
        check("vl0_ready_back",  32'(bus.issue_ready), 32'd1);
        check("vl0_done_clear",  32'(bus.done),        32'd0);

        // vl=24 with a 3-cycle stall on group 1
        push_beat(0, 8'hFF, 0, 1, 9, 0);
        push_beat(1, 8'hFF, 0, 1, 9, 0);
        push_beat(2, 8'hFF, 1, 1, 9, 0);
        push_done();
        do_issue(24, 1, 9, 0);
        tick();
        bus.ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(bus.ex_valid),    32'd1);
            check("stall_group", 32'(bus.rf_rd_group), 32'd1);
            check("stall_mask",  32'(bus.lane_mask),   32'hFF);
            check("stall_addr",  32'(bus.rf_rd_addr),  32'd1);
            check("stall_last",  32'(bus.ex_last),     32'd0);
            tick();
        end
        bus.ex_ready = 1'b1;
        wait_idle();

        // vl=100 clamps to 64: eight full groups
        for (int g = 0; g < 8; g++) push_beat(g, 8'hFF, (g == 7), 12, 14, 0);
        push_done();
        do_issue(100, 12, 14, 0);
        wait_idle();

        // vl=64 aborted by reset while group 2 is presented
        push_beat(0, 8'hFF, 0, 6, 8, 0);
        push_beat(1, 8'hFF, 0, 6, 8, 0);
        do_issue(64, 6, 8, 0);
        tick();
        tick();
        bus.ex_ready = 1'b0;
        @(negedge clk);
        check("abort_pre_group", 32'(bus.rf_rd_group), 32'd2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.ex_ready = 1'b1;
        @(negedge clk);
        check("abort_ex_valid",    32'(bus.ex_valid),    32'd0);
        check("abort_issue_ready", 32'(bus.issue_ready), 32'd1);
        check("abort_done",        32'(bus.done),        32'd0);
        check("abort_busy",        32'(bus.busy),        32'd0);
        repeat (3) tick();

        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
